// File: rtl/rotary_pkg.sv
// Shared types and defaults for the rotary field editor.
package rotary_pkg;

    typedef enum logic [1:0] {
        NAV    = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int DEF_NUM_FIELDS  = 4;
    localparam int DEF_FIELD_WIDTH = 4;
    localparam int DEF_FIELD_MAX   = 9;
    localparam int DEF_WRAP        = 1;

    function automatic int cursor_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rotary_wrap_counter.sv
// Up/down counter bounded to [0, MAX] with wrap or saturate and a load port.
module rotary_wrap_counter #(
    parameter int W    = 4,
    parameter int MAX  = 9,
    parameter int WRAP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic [W-1:0] next_value
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    always_comb begin
        next_value = value;
        if (load) begin
            next_value = load_value;
        end else if (inc && !dec) begin
            if (value == MAXV)
                next_value = (WRAP != 0) ? '0 : MAXV;
            else
                next_value = value + W'(1);
        end else if (dec && !inc) begin
            if (value == '0)
                next_value = (WRAP != 0) ? MAXV : '0;
            else
                next_value = value - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            value <= '0;
        else
            value <= next_value;
    end

endmodule

// File: rtl/rotary_field_editor.sv
// Cursor/edit/commit controller driven by debounced rotary pulses.
import rotary_pkg::*;

module rotary_field_editor #(
    parameter int NUM_FIELDS  = DEF_NUM_FIELDS,
    parameter int FIELD_WIDTH = DEF_FIELD_WIDTH,
    parameter int FIELD_MAX   = DEF_FIELD_MAX,
    parameter int WRAP        = DEF_WRAP
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                right,
    input  logic                                left,
    input  logic                                down,
    input  logic                                wr_ack,
    output logic [cursor_width(NUM_FIELDS)-1:0] cursor,
    output logic                                edit_mode,
    output logic [FIELD_WIDTH-1:0]              field_value,
    output logic                                wr_req,
    output logic [cursor_width(NUM_FIELDS)-1:0] wr_addr,
    output logic [FIELD_WIDTH-1:0]              wr_data
);

    localparam int CW = cursor_width(NUM_FIELDS);

    state_t state;
    state_t state_n;

    logic [FIELD_WIDTH-1:0] fields [NUM_FIELDS];
    logic [FIELD_WIDTH-1:0] shadow;
    logic [FIELD_WIDTH-1:0] shadow_n;
    logic [CW-1:0]          cursor_n;

    logic rot_r;
    logic rot_l;
    logic commit_fire;
    logic edit_start;
    logic edit_done;
    logic [FIELD_WIDTH-1:0] fv_n;

    // A press always wins over rotation; opposing rotations cancel.
    assign rot_r = right && !left && !down;
    assign rot_l = left && !right && !down;

    assign edit_start  = (state == NAV) && down;
    assign edit_done   = (state == EDIT) && down;
    assign commit_fire = (state == COMMIT) && wr_ack;

    always_comb begin
        state_n = state;
        case (state)
            NAV:     if (down) state_n = EDIT;
            EDIT:    if (down) state_n = COMMIT;
            COMMIT:  if (wr_ack) state_n = NAV;
            default: state_n = NAV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= NAV;
        else
            state <= state_n;
    end

    rotary_wrap_counter #(
        .W    (CW),
        .MAX  (NUM_FIELDS - 1),
        .WRAP (1)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .inc        ((state == NAV) && rot_r),
        .dec        ((state == NAV) && rot_l),
        .load       (1'b0),
        .load_value ('0),
        .value      (cursor),
        .next_value (cursor_n)
    );

    rotary_wrap_counter #(
        .W    (FIELD_WIDTH),
        .MAX  (FIELD_MAX),
        .WRAP (WRAP)
    ) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .inc        ((state == EDIT) && rot_r),
        .dec        ((state == EDIT) && rot_l),
        .load       (edit_start),
        .load_value (fields[cursor]),
        .value      (shadow),
        .next_value (shadow_n)
    );

    // On the commit edge the written slot equals shadow.
    always_comb begin
        fv_n = fields[cursor_n];
        if (state_n != NAV)
            fv_n = shadow_n;
        else if (commit_fire)
            fv_n = shadow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++)
                fields[i] <= '0;
            edit_mode   <= 1'b0;
            field_value <= '0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            if (commit_fire)
                fields[cursor] <= shadow;
            edit_mode   <= (state_n != NAV);
            field_value <= fv_n;
            if (edit_done) begin
                wr_req  <= 1'b1;
                wr_addr <= cursor;
                wr_data <= shadow;
            end else if (commit_fire) begin
                wr_req <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rotary_field_editor.md
# rotary_field_editor

Controller that sequences the debounced rotary-encoder event pulses (`right`, `left`, `down` from RotaryButtonInterpret) into a field-editing user interface. The block moves a cursor across a bank of small numeric fields, enters edit mode on a press, steps the selected field's value with rotation, and commits the value through a request/acknowledge write port. It sits between the rotary interpreter and any configuration register file or display driver on the board.

## Interface
Parameters:
- `NUM_FIELDS`, 4: number of editable fields; must be at least 2.
- `FIELD_WIDTH`, 4: bits per field value.
- `FIELD_MAX`, 9: largest legal field value; must be at most 2^FIELD_WIDTH−1.
- `WRAP`, 1: 1 means edit values wrap between 0 and FIELD_MAX; 0 means they saturate.

Ports:
- `clk` in 1: single clock. Everything is posedge.
- `reset` in 1: synchronous, active-high.
- `right` in 1: one-cycle clockwise pulse.
- `left` in 1: one-cycle counter-clockwise pulse.
- `down` in 1: one-cycle press pulse.
- `wr_ack` in 1: downstream acceptance of the commit.
- `cursor` out clog2(NUM_FIELDS): index of the selected field.
- `edit_mode` out 1: high in EDIT and COMMIT.
- `field_value` out FIELD_WIDTH: value to display for the selected field.
- `wr_req` out 1: commit request.
- `wr_addr` out clog2(NUM_FIELDS): commit address.
- `wr_data` out FIELD_WIDTH: commit data.

## Operation
- The block has three states: NAV, EDIT and COMMIT. Reset enters NAV.
- Internal storage:
  - `fields[NUM_FIELDS]`: committed field values.
  - `shadow`: the value being edited.
- Input qualification, applied in every state:
  - `right` and `left` high together: both are ignored.
  - `down` together with a rotation pulse: `down` wins and the rotation is dropped.
- NAV state:
  - `right`: cursor+1, wrapping from NUM_FIELDS−1 to 0.
  - `left`: cursor−1, wrapping from 0 to NUM_FIELDS−1.
  - `down`: load `shadow` with `fields[cursor]`, then go to EDIT.
- EDIT state:
  - `right`: shadow+1. At FIELD_MAX it goes to 0 if WRAP, otherwise it holds.
  - `left`: shadow−1. At 0 it goes to FIELD_MAX if WRAP, otherwise it holds.
  - `down`: set `wr_req`=1, `wr_addr`=cursor, `wr_data`=shadow, then go to COMMIT.
  - The cursor is frozen in EDIT.
- COMMIT state:
  - All `right`, `left` and `down` pulses are dropped, not queued.
  - `wr_addr` and `wr_data` stay stable while `wr_req` is high.
  - On the edge where `wr_ack`=1 is sampled: write `shadow` into `fields[cursor]`, clear `wr_req`, go to NAV.
  - No timeout; COMMIT waits indefinitely.
- `wr_ack` is ignored whenever `wr_req` is low.
- `field_value`:
  - In EDIT and COMMIT it shows `shadow`.
  - In NAV it shows `fields[cursor]`.
- Reset mid-operation, including mid-COMMIT: all state clears immediately and `wr_req` drops on that edge. No write is performed.
- Arithmetic is unsigned FIELD_WIDTH. Values above FIELD_MAX are never produced.

## Timing
- Reset values:
  - `cursor`=0, `edit_mode`=0, `field_value`=0.
  - `wr_req`=0, `wr_addr`=0, `wr_data`=0.
  - All `fields`=0, `shadow`=0, state=NAV.
- All outputs are registered. A pulse sampled at edge n is reflected on the outputs after edge n, giving one-cycle latency.
- `wr_req` rises on the edge that samples `down` in EDIT.
- The fastest handshake is `wr_ack` high in the cycle after `wr_req` rises. `wr_req` then stays high for 1 cycle.
- `wr_req` falls, `edit_mode` falls, and `fields` updates on the same edge.
- Back-to-back input pulses on consecutive cycles are each honoured. No pulse is lost in NAV or EDIT.

## Structure
- Package `rotary_pkg` holds:
  - the state enum (NAV, EDIT, COMMIT),
  - default values for the parameters,
  - a function computing the cursor width.
- Sub-module `rotary_wrap_counter`: a parameterised up/down counter with MAX and WRAP/saturate options, plus a load port.
  - One instance drives `cursor`, with MAX=NUM_FIELDS−1 and WRAP=1.
  - One instance drives `shadow`, with MAX=FIELD_MAX and the block's WRAP setting, loaded on entry to EDIT.
- The top level holds the FSM, the field array and the write-port registers.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs 0, state NAV. Then 5 `right` pulses with NUM_FIELDS=4 → cursor steps 1,2,3,0,1. Then 2 `left` pulses → cursor 0, then 3.
- Edit and commit:
  - From reset, `down` → edit_mode=1, field_value=0.
  - 3 `right` → field_value=3.
  - `down` → wr_req=1, wr_addr=0, wr_data=3.
  - `wr_ack` after 4 cycles → wr_req=0, edit_mode=0 on that edge, field_value=3.
- Wrap and saturate in EDIT, starting from 9:
  - WRAP=1: `right` → 0, then `left` → 9.
  - WRAP=0: `right` holds 9; from 0, `left` holds 0.
- Simultaneous events:
  - `right`+`left` in the same cycle → no change.
  - `down`+`right` in NAV → enters EDIT with the cursor unchanged.
- COMMIT lockout: while wr_req=1, pulse `right`, `left` and `down` → wr_data and cursor unchanged. After `wr_ack`, state is NAV and there is no second request.
- Reset mid-COMMIT: assert `reset` while wr_req=1 → wr_req=0 next edge, fields remain 0, state NAV. A late `wr_ack` is ignored.
